// File: rtl/nebula_mem_responder.sv
// -----------------------------------------------------------------------------
// nebula_mem_responder
//
// Memory-side responder for the core's three request ports: imem (line read),
// dmem (line read/write) and ptw (XLEN-bit PTE read). One port is granted at a
// time in round-robin order ptw -> dmem -> imem. The granted request is served
// from an internal line-wide SRAM after LATENCY cycles. A one-cycle registered
// ack carries the data and error flag back to the granted port.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req/addr                  line read request (level), byte address
//   imem_ack/data/error            response pulse, line data, error flag
//   dmem_req/we/addr/wdata         line read (we=0) or full-line write (we=1)
//   dmem_is_amo/amo_op             AMO request (always errors), opcode ignored
//   dmem_ack/rdata/error           response pulse, read data, error flag
//   ptw_mem_req/addr               PTE word read request (level), byte address
//   ptw_mem_ack/data/error         response pulse, PTE word, error flag
//
// Responses with error=1 return zero data and never write the SRAM. All data
// outputs are zero whenever the matching ack is low. SRAM contents survive
// reset.
// -----------------------------------------------------------------------------
module nebula_mem_responder #(
  parameter int                     PADDR_WIDTH = 56,
  parameter int                     XLEN        = 64,
  parameter int                     LINE_SIZE   = 64,
  parameter logic [PADDR_WIDTH-1:0] MEM_BASE    = PADDR_WIDTH'(64'h8000_0000),
  parameter int                     MEM_LINES   = 1024,
  parameter int                     LATENCY     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     imem_req,
  input  logic [PADDR_WIDTH-1:0]   imem_addr,
  output logic                     imem_ack,
  output logic [LINE_SIZE*8-1:0]   imem_data,
  output logic                     imem_error,
  input  logic                     dmem_req,
  input  logic                     dmem_we,
  input  logic [PADDR_WIDTH-1:0]   dmem_addr,
  input  logic [LINE_SIZE*8-1:0]   dmem_wdata,
  input  logic                     dmem_is_amo,
  input  logic [4:0]               dmem_amo_op,
  output logic                     dmem_ack,
  output logic [LINE_SIZE*8-1:0]   dmem_rdata,
  output logic                     dmem_error,
  input  logic                     ptw_mem_req,
  input  logic [PADDR_WIDTH-1:0]   ptw_mem_addr,
  output logic                     ptw_mem_ack,
  output logic [XLEN-1:0]          ptw_mem_data,
  output logic                     ptw_mem_error
);

  localparam int LINE_W = LINE_SIZE * 8;
  localparam int OFF_W  = $clog2(LINE_SIZE);
  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int WSEL_W = $clog2(LINE_W / XLEN);
  localparam int BOFF_W = $clog2(XLEN / 8);
  localparam int CNT_W  = $clog2(LATENCY + 1);

  localparam logic [PADDR_WIDTH-1:0] MEM_SPAN  = PADDR_WIDTH'(MEM_LINES * LINE_SIZE);
  localparam logic [LINE_W-1:0]      ZERO_LINE = {LINE_W{1'b0}};
  localparam logic [XLEN-1:0]        ZERO_WORD = {XLEN{1'b0}};

  // Port codes double as bit positions in req_vec_s.
  localparam logic [1:0] PORT_PTW  = 2'd0;
  localparam logic [1:0] PORT_DMEM = 2'd1;
  localparam logic [1:0] PORT_IMEM = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  // Round-robin successor: ptw -> dmem -> imem -> ptw.
  function automatic logic [1:0] next_port(input logic [1:0] p);
    logic [1:0] n;
    case (p)
      PORT_PTW:  n = PORT_DMEM;
      PORT_DMEM: n = PORT_IMEM;
      default:   n = PORT_PTW;
    endcase
    return n;
  endfunction

  // Out-of-window address, misaligned PTE read, or AMO.
  function automatic logic req_fault(input logic [PADDR_WIDTH-1:0] addr,
                                     input logic                   is_ptw,
                                     input logic                   is_amo);
    logic [PADDR_WIDTH-1:0] off;
    logic                   out_of_range;
    logic                   misaligned;
    off          = addr - MEM_BASE;
    out_of_range = (addr < MEM_BASE) || (off >= MEM_SPAN);
    misaligned   = is_ptw && (addr[BOFF_W-1:0] != {BOFF_W{1'b0}});
    return out_of_range || misaligned || is_amo;
  endfunction

  state_t                   state_r;
  state_t                   next_state_s;
  logic [CNT_W-1:0]         cnt_r;
  logic [1:0]               rr_r;
  logic [1:0]               gnt_port_r;
  logic [PADDR_WIDTH-1:0]   lat_addr_r;
  logic                     lat_we_r;
  logic                     lat_amo_r;
  logic [LINE_W-1:0]        lat_wdata_r;

  logic [3:0]               req_vec_s;
  logic [1:0]               p0_s;
  logic [1:0]               p1_s;
  logic [1:0]               p2_s;
  logic                     arb_valid_s;
  logic [1:0]               arb_port_s;
  logic                     grant_s;
  logic                     resp_s;
  logic                     commit_s;

  logic [1:0]               cur_port_s;
  logic [PADDR_WIDTH-1:0]   cur_addr_s;
  logic                     cur_we_s;
  logic                     cur_amo_s;
  logic [LINE_W-1:0]        cur_wdata_s;
  logic                     cur_err_s;
  logic [PADDR_WIDTH-1:0]   cur_off_s;
  logic [IDX_W-1:0]         cur_idx_s;
  logic [WSEL_W-1:0]        cur_wsel_s;
  logic [LINE_W-1:0]        rd_line_s;
  logic [XLEN-1:0]          rd_word_s;
  logic                     unused_s;

  logic [LINE_W-1:0]        mem_r [MEM_LINES];

  assign req_vec_s = {1'b0, imem_req, dmem_req, ptw_mem_req};
  assign p0_s      = rr_r;
  assign p1_s      = next_port(p0_s);
  assign p2_s      = next_port(p1_s);

  // Round-robin pick starting at the pointer.
  always_comb begin
    arb_valid_s = 1'b0;
    arb_port_s  = rr_r;
    if (req_vec_s[p0_s]) begin
      arb_valid_s = 1'b1;
      arb_port_s  = p0_s;
    end else if (req_vec_s[p1_s]) begin
      arb_valid_s = 1'b1;
      arb_port_s  = p1_s;
    end else if (req_vec_s[p2_s]) begin
      arb_valid_s = 1'b1;
      arb_port_s  = p2_s;
    end else begin
      arb_valid_s = 1'b0;
      arb_port_s  = rr_r;
    end
  end

  // FSM next-state; grants happen only in IDLE.
  always_comb begin
    next_state_s = state_r;
    grant_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arb_valid_s) begin
          grant_s = 1'b1;
          // BUSY spans LATENCY-1 cycles; with LATENCY=1 it is skipped.
          if (LATENCY == 1) begin
            next_state_s = ST_RESP;
          end else begin
            next_state_s = ST_BUSY;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      ST_RESP:    next_state_s = ST_RECOVER;
      ST_RECOVER: next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // Current request: live inputs while granting (needed when LATENCY=1), latched fields otherwise.
  always_comb begin
    cur_port_s  = gnt_port_r;
    cur_addr_s  = lat_addr_r;
    cur_we_s    = lat_we_r;
    cur_amo_s   = lat_amo_r;
    cur_wdata_s = lat_wdata_r;
    if (state_r == ST_IDLE) begin
      cur_port_s = arb_port_s;
      case (arb_port_s)
        PORT_PTW: begin
          cur_addr_s  = ptw_mem_addr;
          cur_we_s    = 1'b0;
          cur_amo_s   = 1'b0;
          cur_wdata_s = ZERO_LINE;
        end
        PORT_DMEM: begin
          cur_addr_s  = dmem_addr;
          cur_we_s    = dmem_we;
          cur_amo_s   = dmem_is_amo;
          cur_wdata_s = dmem_wdata;
        end
        default: begin
          cur_addr_s  = imem_addr;
          cur_we_s    = 1'b0;
          cur_amo_s   = 1'b0;
          cur_wdata_s = ZERO_LINE;
        end
      endcase
    end else begin
      cur_port_s  = gnt_port_r;
      cur_addr_s  = lat_addr_r;
      cur_we_s    = lat_we_r;
      cur_amo_s   = lat_amo_r;
      cur_wdata_s = lat_wdata_r;
    end
  end

  assign cur_err_s  = req_fault(cur_addr_s, cur_port_s == PORT_PTW, cur_amo_s);
  assign cur_off_s  = cur_addr_s - MEM_BASE;
  assign cur_idx_s  = cur_off_s[OFF_W +: IDX_W];
  assign cur_wsel_s = cur_addr_s[BOFF_W +: WSEL_W];
  assign rd_line_s  = mem_r[cur_idx_s];
  assign rd_word_s  = rd_line_s[cur_wsel_s * XLEN +: XLEN];

  // The SRAM access and response registers update on the edge that enters RESP.
  assign resp_s   = (next_state_s == ST_RESP);
  assign commit_s = resp_s && (cur_port_s == PORT_DMEM) && cur_we_s && !cur_err_s;

  // Offset bits and the AMO opcode have no function here.
  assign unused_s = ^{dmem_amo_op, cur_off_s};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request latch, latency counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_r        <= PORT_PTW;
      cnt_r       <= {CNT_W{1'b0}};
      gnt_port_r  <= PORT_PTW;
      lat_addr_r  <= {PADDR_WIDTH{1'b0}};
      lat_we_r    <= 1'b0;
      lat_amo_r   <= 1'b0;
      lat_wdata_r <= ZERO_LINE;
    end else if (grant_s) begin
      rr_r        <= next_port(arb_port_s);
      cnt_r       <= (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : {CNT_W{1'b0}};
      gnt_port_r  <= cur_port_s;
      lat_addr_r  <= cur_addr_s;
      lat_we_r    <= cur_we_s;
      lat_amo_r   <= cur_amo_s;
      lat_wdata_r <= cur_wdata_s;
    end else if ((state_r == ST_BUSY) && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  // Registered one-cycle responses; data is forced to zero off-ack and on error.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_ack      <= 1'b0;
      imem_data     <= ZERO_LINE;
      imem_error    <= 1'b0;
      dmem_ack      <= 1'b0;
      dmem_rdata    <= ZERO_LINE;
      dmem_error    <= 1'b0;
      ptw_mem_ack   <= 1'b0;
      ptw_mem_data  <= ZERO_WORD;
      ptw_mem_error <= 1'b0;
    end else begin
      imem_ack      <= 1'b0;
      imem_data     <= ZERO_LINE;
      imem_error    <= 1'b0;
      dmem_ack      <= 1'b0;
      dmem_rdata    <= ZERO_LINE;
      dmem_error    <= 1'b0;
      ptw_mem_ack   <= 1'b0;
      ptw_mem_data  <= ZERO_WORD;
      ptw_mem_error <= 1'b0;
      if (resp_s) begin
        case (cur_port_s)
          PORT_PTW: begin
            ptw_mem_ack   <= 1'b1;
            ptw_mem_error <= cur_err_s;
            ptw_mem_data  <= cur_err_s ? ZERO_WORD : rd_word_s;
          end
          PORT_DMEM: begin
            dmem_ack   <= 1'b1;
            dmem_error <= cur_err_s;
            dmem_rdata <= (cur_err_s || cur_we_s) ? ZERO_LINE : rd_line_s;
          end
          default: begin
            imem_ack   <= 1'b1;
            imem_error <= cur_err_s;
            imem_data  <= cur_err_s ? ZERO_LINE : rd_line_s;
          end
        endcase
      end
    end
  end

  // Line SRAM; not cleared by reset, and a write is never committed under reset.
  always_ff @(posedge clk) begin
    if (commit_s && !rst) begin
      mem_r[cur_idx_s] <= cur_wdata_s;
    end
  end

endmodule

// File: tb/tb_nebula_mem_responder.sv
module tb_nebula_mem_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         imem_req = 1'b0;
  logic [55:0]  imem_addr = 56'd0;
  logic         imem_ack;
  logic [511:0] imem_data;
  logic         imem_error;
  logic         dmem_req = 1'b0;
  logic         dmem_we = 1'b0;
  logic [55:0]  dmem_addr = 56'd0;
  logic [511:0] dmem_wdata = 512'd0;
  logic         dmem_is_amo = 1'b0;
  logic [4:0]   dmem_amo_op = 5'd0;
  logic         dmem_ack;
  logic [511:0] dmem_rdata;
  logic         dmem_error;
  logic         ptw_mem_req = 1'b0;
  logic [55:0]  ptw_mem_addr = 56'd0;
  logic         ptw_mem_ack;
  logic [63:0]  ptw_mem_data;
  logic         ptw_mem_error;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference memory: line index -> contents, only lines the bench has written.
  logic [511:0] mem_m [int];

  localparam longint BASE = 64'h8000_0000;
  localparam longint SPAN = 1024 * 64;

  nebula_mem_responder dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .imem_error(imem_error),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_is_amo(dmem_is_amo), .dmem_amo_op(dmem_amo_op),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_error(dmem_error),
    .ptw_mem_req(ptw_mem_req), .ptw_mem_addr(ptw_mem_addr), .ptw_mem_ack(ptw_mem_ack),
    .ptw_mem_data(ptw_mem_data), .ptw_mem_error(ptw_mem_error)
  );

  always #5 clk = ~clk;

  // Continuous rules: at most one ack per cycle, quiet outputs when ack is low.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (int'(imem_ack) + int'(dmem_ack) + int'(ptw_mem_ack) > 1) begin
        errors++;
        $display("FAIL multi_ack got=%b%b%b exp=at most one", ptw_mem_ack, dmem_ack, imem_ack);
      end
      checks++;
      if ((!imem_ack && (imem_data !== 512'd0 || imem_error !== 1'b0)) ||
          (!dmem_ack && (dmem_rdata !== 512'd0 || dmem_error !== 1'b0)) ||
          (!ptw_mem_ack && (ptw_mem_data !== 64'd0 || ptw_mem_error !== 1'b0))) begin
        errors++;
        $display("FAIL idle_outputs_nonzero got=nonzero exp=0");
      end
    end
  end

  // Spec-level model: port 0=ptw, 1=dmem, 2=imem.
  task automatic model_access(input int port, input logic [55:0] addr, input logic we,
                              input logic [511:0] wd, input logic amo,
                              output logic [511:0] rd, output logic er);
    longint a;
    int     line;
    int     w;
    logic [511:0] l;
    a  = longint'(addr);
    er = (a < BASE) || (a >= BASE + SPAN) || (port == 0 && (a % 8) != 0) || (port == 1 && amo);
    rd = 512'd0;
    if (!er) begin
      line = int'((a - BASE) / 64);
      if (port == 1 && we) begin
        mem_m[line] = wd;
      end else if (port == 0) begin
        w  = int'((a % 64) / 8);
        l  = mem_m[line];
        rd = {448'd0, l[w*64 +: 64]};
      end else begin
        rd = mem_m[line];
      end
    end
  endtask

  function automatic logic [511:0] rnd_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One request from IDLE; returns data, error and cycles from grant to ack (-1 on timeout).
  task automatic do_req(input int port, input logic [55:0] addr, input logic we,
                        input logic [511:0] wd, input logic amo,
                        output logic [511:0] rd, output logic er, output int lat);
    int n;
    lat = -1;
    rd  = 512'd0;
    er  = 1'b0;
    case (port)
      0: begin ptw_mem_addr = addr; ptw_mem_req = 1'b1; end
      1: begin dmem_addr = addr; dmem_we = we; dmem_wdata = wd; dmem_is_amo = amo;
               dmem_amo_op = 5'($urandom); dmem_req = 1'b1; end
      default: begin imem_addr = addr; imem_req = 1'b1; end
    endcase
    for (n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (port == 0 && ptw_mem_ack) begin rd = {448'd0, ptw_mem_data}; er = ptw_mem_error; lat = n; break; end
      if (port == 1 && dmem_ack) begin rd = dmem_rdata; er = dmem_error; lat = n; break; end
      if (port == 2 && imem_ack) begin rd = imem_data; er = imem_error; lat = n; break; end
    end
    ptw_mem_req = 1'b0;
    dmem_req    = 1'b0;
    imem_req    = 1'b0;
    dmem_is_amo = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    checks++;
    if ({imem_ack, dmem_ack, ptw_mem_ack} !== 3'b000) begin
      errors++; $display("FAIL reset_acks got=%b exp=000", {imem_ack, dmem_ack, ptw_mem_ack});
    end
    checks++;
    if ({imem_error, dmem_error, ptw_mem_error} !== 3'b000) begin
      errors++; $display("FAIL reset_errors got=%b exp=000", {imem_error, dmem_error, ptw_mem_error});
    end
    checks++;
    if (imem_data !== 512'd0 || dmem_rdata !== 512'd0 || ptw_mem_data !== 64'd0) begin
      errors++; $display("FAIL reset_data got=nonzero exp=0");
    end
  endtask

  task automatic test_write_read();
    logic [511:0] rd, ex;
    logic er, ee;
    int lat;
    model_access(1, 56'h8000_0040, 1'b1, {64{8'hA5}}, 1'b0, ex, ee);
    do_req(1, 56'h8000_0040, 1'b1, {64{8'hA5}}, 1'b0, rd, er, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL wr_latency got=%0d exp=4", lat); end
    checks++;
    if (rd !== ex || er !== ee) begin errors++; $display("FAIL wr_resp got=%h/%b exp=%h/%b", rd, er, ex, ee); end
    model_access(1, 56'h8000_0040, 1'b0, 512'd0, 1'b0, ex, ee);
    do_req(1, 56'h8000_0040, 1'b0, 512'd0, 1'b0, rd, er, lat);
    checks++;
    if (rd !== ex || er !== ee) begin errors++; $display("FAIL rd_after_wr got=%h/%b exp=%h/%b", rd, er, ex, ee); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL rd_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_ptw_word();
    logic [511:0] l, rd, ex;
    logic er, ee;
    int lat;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = 64'(k);
    model_access(1, 56'h8000_0000, 1'b1, l, 1'b0, ex, ee);
    do_req(1, 56'h8000_0000, 1'b1, l, 1'b0, rd, er, lat);
    do_req(0, 56'h8000_0028, 1'b0, 512'd0, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 512'd5 || er !== 1'b0) begin errors++; $display("FAIL ptw_word5 got=%h/%b exp=5/0", rd[63:0], er); end
    do_req(0, 56'h8000_002C, 1'b0, 512'd0, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 512'd0 || er !== 1'b1) begin errors++; $display("FAIL ptw_misaligned got=%h/%b exp=0/1", rd[63:0], er); end
  endtask

  task automatic test_errors();
    logic [511:0] rd, ex;
    logic er, ee;
    int lat;
    do_req(2, 56'h7FFF_FFC0, 1'b0, 512'd0, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 512'd0 || er !== 1'b1) begin errors++; $display("FAIL imem_below_base got=%h/%b exp=0/1", rd, er); end
    do_req(2, 56'h8001_0000, 1'b0, 512'd0, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 512'd0 || er !== 1'b1) begin errors++; $display("FAIL imem_past_end got=%h/%b exp=0/1", rd, er); end
    // An out-of-range write whose offset bits alias line 0 must not land anywhere.
    do_req(1, 56'h8001_0000, 1'b1, {64{8'h3C}}, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 512'd0 || er !== 1'b1) begin errors++; $display("FAIL dmem_wr_past_end got=%h/%b exp=0/1", rd, er); end
    model_access(2, 56'h8000_0000, 1'b0, 512'd0, 1'b0, ex, ee);
    do_req(2, 56'h8000_0000, 1'b0, 512'd0, 1'b0, rd, er, lat);
    checks++;
    if (rd !== ex || er !== ee) begin errors++; $display("FAIL sram_unchanged got=%h exp=%h", rd, ex); end
  endtask

  task automatic test_amo();
    logic [511:0] rd, ex;
    logic er, ee;
    int lat;
    do_req(1, 56'h8000_0000, 1'b1, {64{8'hEE}}, 1'b1, rd, er, lat);
    checks++;
    if (rd !== 512'd0 || er !== 1'b1 || lat !== 4) begin
      errors++; $display("FAIL amo_resp got=%h/%b/%0d exp=0/1/4", rd, er, lat);
    end
    model_access(1, 56'h8000_0000, 1'b0, 512'd0, 1'b0, ex, ee);
    do_req(1, 56'h8000_0000, 1'b0, 512'd0, 1'b0, rd, er, lat);
    checks++;
    if (rd !== ex || er !== ee) begin errors++; $display("FAIL amo_no_write got=%h exp=%h", rd, ex); end
  endtask

  task automatic test_arbitration();
    int cyc [3];
    logic [511:0] got [3];
    logic [511:0] ex [3];
    logic gerr [3];
    logic eerr [3];
    int exp_cyc [3];
    exp_cyc = '{4, 10, 16};
    cyc = '{-1, -1, -1};
    do_reset();
    model_access(0, 56'h8000_0028, 1'b0, 512'd0, 1'b0, ex[0], eerr[0]);
    model_access(1, 56'h8000_0040, 1'b0, 512'd0, 1'b0, ex[1], eerr[1]);
    model_access(2, 56'h8000_0000, 1'b0, 512'd0, 1'b0, ex[2], eerr[2]);
    ptw_mem_addr = 56'h8000_0028;
    dmem_addr = 56'h8000_0040; dmem_we = 1'b0; dmem_is_amo = 1'b0;
    imem_addr = 56'h8000_0000;
    imem_req = 1'b1; dmem_req = 1'b1; ptw_mem_req = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ptw_mem_ack) begin cyc[0] = n; got[0] = {448'd0, ptw_mem_data}; gerr[0] = ptw_mem_error; ptw_mem_req = 1'b0; end
      if (dmem_ack) begin cyc[1] = n; got[1] = dmem_rdata; gerr[1] = dmem_error; dmem_req = 1'b0; end
      if (imem_ack) begin cyc[2] = n; got[2] = imem_data; gerr[2] = imem_error; imem_req = 1'b0; end
      if (cyc[0] > 0 && cyc[1] > 0 && cyc[2] > 0) break;
    end
    imem_req = 1'b0; dmem_req = 1'b0; ptw_mem_req = 1'b0;
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (cyc[p] !== exp_cyc[p]) begin errors++; $display("FAIL rr_ack_cycle port%0d got=%0d exp=%0d", p, cyc[p], exp_cyc[p]); end
      checks++;
      if (cyc[p] > 0 && (got[p] !== ex[p] || gerr[p] !== eerr[p])) begin
        errors++; $display("FAIL rr_data port%0d got=%h exp=%h", p, got[p], ex[p]);
      end
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [511:0] d1, d2, rd, ex;
    logic er, ee;
    int lat, acks;
    d1 = rnd_line();
    d2 = ~d1;
    model_access(1, 56'h8000_0080, 1'b1, d1, 1'b0, ex, ee);
    do_req(1, 56'h8000_0080, 1'b1, d1, 1'b0, rd, er, lat);
    // Abandoned write: reset during BUSY, requester gives up.
    acks = 0;
    dmem_addr = 56'h8000_0080; dmem_we = 1'b1; dmem_wdata = d2; dmem_req = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    acks += int'(dmem_ack);
    rst = 1'b1; dmem_req = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); @(negedge clk);
      acks += int'(dmem_ack) + int'(imem_ack) + int'(ptw_mem_ack);
    end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL rst_mid_no_ack got=%0d exp=0", acks); end
    model_access(1, 56'h8000_0080, 1'b0, 512'd0, 1'b0, ex, ee);
    do_req(1, 56'h8000_0080, 1'b0, 512'd0, 1'b0, rd, er, lat);
    checks++;
    if (rd !== ex || er !== ee) begin errors++; $display("FAIL rst_mid_line_kept got=%h exp=%h", rd, ex); end
    // Held request across reset is re-served from IDLE.
    dmem_addr = 56'h8000_0080; dmem_we = 1'b1; dmem_wdata = d2; dmem_req = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); @(negedge clk);
      if (dmem_ack) begin lat = n; er = dmem_error; rd = dmem_rdata; break; end
    end
    dmem_req = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++;
    if (lat !== 4 || er !== 1'b0 || rd !== 512'd0) begin
      errors++; $display("FAIL rst_held_reserved got=%0d/%b exp=4/0", lat, er);
    end
    model_access(1, 56'h8000_0080, 1'b1, d2, 1'b0, ex, ee);
    model_access(1, 56'h8000_0080, 1'b0, 512'd0, 1'b0, ex, ee);
    do_req(1, 56'h8000_0080, 1'b0, 512'd0, 1'b0, rd, er, lat);
    checks++;
    if (rd !== ex) begin errors++; $display("FAIL rst_held_written got=%h exp=%h", rd, ex); end
  endtask

  task automatic test_random();
    logic [511:0] rd, ex, wd;
    logic [55:0]  addr;
    logic er, ee, we, amo;
    int lat, port, line, kind;
    for (int l = 0; l < 16; l++) begin
      wd = rnd_line();
      addr = 56'(BASE + longint'(l) * 64);
      model_access(1, addr, 1'b1, wd, 1'b0, ex, ee);
      do_req(1, addr, 1'b1, wd, 1'b0, rd, er, lat);
    end
    for (int t = 0; t < 60; t++) begin
      port = int'($urandom_range(0, 2));
      line = int'($urandom_range(0, 15));
      kind = int'($urandom_range(0, 9));
      we   = (port == 1) ? 1'($urandom) : 1'b0;
      amo  = (port == 1 && kind == 1) ? 1'b1 : 1'b0;
      wd   = rnd_line();
      if (kind == 0) begin
        addr = ($urandom_range(0, 1) == 0) ? 56'(BASE - 64 * longint'($urandom_range(1, 100)))
                                           : 56'(BASE + SPAN + 64 * longint'($urandom_range(0, 100)));
      end else if (port == 0) begin
        addr = 56'(BASE + longint'(line) * 64 + 8 * longint'($urandom_range(0, 7)) +
                   ((kind == 2) ? longint'($urandom_range(1, 7)) : 64'd0));
      end else begin
        addr = 56'(BASE + longint'(line) * 64 + longint'($urandom_range(0, 63)));
      end
      model_access(port, addr, we, wd, amo, ex, ee);
      do_req(port, addr, we, wd, amo, rd, er, lat);
      checks++;
      if (rd !== ex || er !== ee || lat !== 4) begin
        errors++;
        $display("FAIL random t=%0d port=%0d addr=%h got=%h/%b/%0d exp=%h/%b/4", t, port, addr, rd, er, lat, ex, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_ptw_word();
    test_errors();
    test_amo();
    test_arbitration();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
